spi_master: RTL and testbench

Byte-oriented SPI initiator (mode 0: CPOL = 0, CPHA = 0) that drives the camera FPGA's SPI slaves from the `main_clock` domain. Each accepted request shifts out one byte MSB-first on `mosi`, captures one byte from `miso`, and pulses `done`. Chip select can be held low across consecutive bytes for multi-byte transactions. Used by on-chip test/configuration logic and as the bench counterpart of the SPI slave blocks.

---
 rtl/spi_master.sv | 179 +++++++++++++++++
 tb/tb_spi_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//
// Byte-oriented SPI initiator, mode 0 (CPOL = 0, CPHA = 0).
//
// Each accepted request does three things:
//   - shifts one byte out on mosi, MSB first;
//   - captures one byte from miso;
//   - pulses done for one cycle.
// Chip select can be held low across consecutive bytes so that several
// bytes form one transaction.
//
// Parameters
//   CLK_DIV     SCK half-period in main_clock cycles (>= 1). Slaves that
//               resample SCK need at least 4.
//
// Ports
//   main_clock  in   system clock; all logic runs on its rising edge
//   rst_n       in   asynchronous, active-low reset
//   start       in   request one byte transfer (acted on only while idle)
//   keep_cs     in   sampled with start: 1 keeps cs low after the byte
//   cs_release  in   while idle, drives cs high on the next edge
//   tx_data     in   byte to send, sampled with start
//   rx_data     out  last received byte, updated together with done
//   busy        out  transfer in progress
//   done        out  one-cycle pulse at the end of a byte
//   sck         out  SPI clock, idles low
//   cs          out  chip select, active low
//   mosi        out  master data out; changes only while sck is low
//   miso        in   slave data in
//
// Byte timing, with E0 = the edge that accepts start and D = CLK_DIV:
//   - rise k (k = 0..7) happens at E0 + D*(1+2k);
//   - fall k happens at E0 + D*(2+2k);
//   - done is set at E0 + 17D;
//   - the next start can be accepted at E0 + 17D + 1.
// ---------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       main_clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic       keep_cs,
    input  logic       cs_release,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] HIGH   = 3'd2;
    localparam logic [2:0] LOW    = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]    state_reg;
    logic [PW-1:0] phase_reg;
    logic [2:0]    bit_cnt_reg;
    // Only bits 6..0 are kept: bit 7 goes straight to mosi on acceptance.
    logic [6:0]    tx_shift_reg;
    logic [7:0]    rx_shift_reg;
    logic          keep_reg;
    // Set at the fall after bit 7, so the following LOW is the CS hold time
    // and its expiry finishes the byte instead of raising sck again.
    logic          hold_reg;

    wire phase_done = (phase_reg == PHASE_LAST);

    always_ff @(posedge main_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            bit_cnt_reg  <= 3'd0;
            tx_shift_reg <= 7'd0;
            rx_shift_reg <= 8'd0;
            keep_reg     <= 1'b0;
            hold_reg     <= 1'b0;
            rx_data      <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sck          <= 1'b0;
            cs           <= 1'b1;
            mosi         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                // FINISH is the cycle in which done is high.
                // The master is already idle in that cycle, so it accepts
                // start exactly like IDLE does. This is what gives the
                // 17D + 1 cycle throughput.
                IDLE, FINISH: begin
                    if (start) begin
                        tx_shift_reg <= tx_data[6:0];
                        mosi         <= tx_data[7];
                        keep_reg     <= keep_cs;
                        hold_reg     <= 1'b0;
                        bit_cnt_reg  <= 3'd0;
                        phase_reg    <= '0;
                        cs           <= 1'b0;
                        busy         <= 1'b1;
                        state_reg    <= SETUP;
                    end else begin
                        if (cs_release) begin
                            cs <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                end

                SETUP: begin
                    if (phase_done) begin
                        phase_reg    <= '0;
                        sck          <= 1'b1;
                        rx_shift_reg <= {rx_shift_reg[6:0], miso};
                        state_reg    <= HIGH;
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end

                HIGH: begin
                    if (phase_done) begin
                        phase_reg <= '0;
                        sck       <= 1'b0;
                        state_reg <= LOW;
                        if (bit_cnt_reg != 3'd7) begin
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            mosi         <= tx_shift_reg[6];
                            tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
                            hold_reg     <= 1'b0;
                        end else begin
                            // mosi keeps bit 0 through the hold period.
                            hold_reg <= 1'b1;
                        end
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end

                LOW: begin
                    if (phase_done) begin
                        phase_reg <= '0;
                        if (hold_reg) begin
                            rx_data   <= rx_shift_reg;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cs        <= ~keep_reg;
                            state_reg <= FINISH;
                        end else begin
                            sck          <= 1'b1;
                            rx_shift_reg <= {rx_shift_reg[6:0], miso};
                            state_reg    <= HIGH;
                        end
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    phase_reg <= '0;
                    busy      <= 1'b0;
                    sck       <= 1'b0;
                    cs        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT with CLK_DIV = 4
    logic       start4, keep4, cs_rel4, miso4;
    logic [7:0] tx4, rx4;
    logic       busy4, done4, sck4, cs4, mosi4;
    logic [1:0] mode4;  // 0 loopback, 1 pattern slave, 2 tie 1, 3 tie 0
    logic [7:0] pat;
    logic       sck4_d;

    // DUT with CLK_DIV = 1, loopback
    logic       start1, keep1, cs_rel1, miso1;
    logic [7:0] tx1, rx1;
    logic       busy1, done1, sck1, cs1, mosi1;

    spi_master #(.CLK_DIV(4)) dut4 (
        .main_clock(clk), .rst_n(rst_n), .start(start4), .keep_cs(keep4),
        .cs_release(cs_rel4), .tx_data(tx4), .rx_data(rx4), .busy(busy4),
        .done(done4), .sck(sck4), .cs(cs4), .mosi(mosi4), .miso(miso4)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .main_clock(clk), .rst_n(rst_n), .start(start1), .keep_cs(keep1),
        .cs_release(cs_rel1), .tx_data(tx1), .rx_data(rx1), .busy(busy1),
        .done(done1), .sck(sck1), .cs(cs1), .mosi(mosi1), .miso(miso1)
    );

    assign miso4 = (mode4 == 2'd0) ? mosi4 :
                   (mode4 == 2'd1) ? pat[7] :
                   (mode4 == 2'd2) ? 1'b1 : 1'b0;
    assign miso1 = mosi1;

    // Constant-pattern slave: reloads 0xAB while deselected and rotates
    // left after every SCK fall.
    always @(posedge clk) begin
        sck4_d <= sck4;
        if (cs4) pat <= 8'hAB;
        else if (sck4_d && !sck4) pat <= {pat[6:0], pat[7]};
    end

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q4[$];
    logic [7:0] q1[$];
    int done_cnt4 = 0, done_cyc4 = 0, rises4 = 0, cs_rises4 = 0;
    int done_cnt1 = 0, done_cyc1 = 0, mosi_viol1 = 0;
    logic sck4_prev = 1'b0, cs4_prev = 1'b1, mosi1_prev = 1'b0;
    int e0, e0_1;

    // Scoreboard / monitors, sampled on the falling edge
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (done4) begin
            done_cnt4++;
            done_cyc4 = cyc;
            vectors++;
            assert (q4.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_done4: observed done with rx=%h, expected no done", rx4);
            end
            if (q4.size() != 0) begin
                exp_b = q4.pop_front();
                assert (rx4 === exp_b) else begin
                    miscompares++;
                    $error("FAIL rx_data4: observed %h expected %h", rx4, exp_b);
                end
                $display("dut4 byte done at cycle %0d rx=%h expected=%h", cyc, rx4, exp_b);
            end
        end
        if (done1) begin
            done_cnt1++;
            done_cyc1 = cyc;
            vectors++;
            assert (q1.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_done1: observed done with rx=%h, expected no done", rx1);
            end
            if (q1.size() != 0) begin
                exp_b = q1.pop_front();
                assert (rx1 === exp_b) else begin
                    miscompares++;
                    $error("FAIL rx_data1: observed %h expected %h", rx1, exp_b);
                end
                $display("dut1 byte done at cycle %0d rx=%h expected=%h", cyc, rx1, exp_b);
            end
        end
        if (sck4 && !sck4_prev) rises4++;
        if (cs4 && !cs4_prev) cs_rises4++;
        if (sck1 && (mosi1 !== mosi1_prev)) mosi_viol1++;
        sck4_prev  = sck4;
        cs4_prev   = cs4;
        mosi1_prev = mosi1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drive one start into dut4 and record E0 (the accepting edge).
    task automatic go4(input logic [7:0] d, input logic k, input logic rel,
                       input logic push, input logic [7:0] exp_b);
        tx4 = d; keep4 = k; cs_rel4 = rel; start4 = 1'b1;
        if (push) q4.push_back(exp_b);
        tick(1);
        e0 = cyc;
        start4 = 1'b0; cs_rel4 = 1'b0;
    endtask

    task automatic wait_done4(input int base);
        int t;
        t = 0;
        while (done_cnt4 == base && t < 400) begin
            tick(1);
            t++;
        end
        check("done4_arrived", 32'(done_cnt4 - base), 32'd1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        start4 = 0; keep4 = 0; cs_rel4 = 0; tx4 = 0; mode4 = 2'd0;
        start1 = 0; keep1 = 0; cs_rel1 = 0; tx1 = 0;
        tick(3);
        check("reset_outputs4", {26'd0, cs4, sck4, mosi4, busy4, done4, 1'b0},
              {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_rx4", {24'd0, rx4}, 32'h00);
        rst_n = 1'b1;
        tick(2);

        // Abort by reset in the middle of a byte (sck is high here)
        go4(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(29);
        check("abort_pre_sck", {31'd0, sck4}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_cs", {31'd0, cs4}, 32'd1);
        check("abort_sck", {31'd0, sck4}, 32'd0);
        check("abort_busy", {31'd0, busy4}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(80);
        check("abort_no_done", done_cnt4, 32'd0);
        check("abort_rx_kept", {24'd0, rx4}, 32'h00);

        // Loopback 0xA5: timing, SCK rise count, CS release
        mode4 = 2'd0;
        rises4 = 0;
        base = done_cnt4;
        go4(8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5);
        check("e0_cs_low", {30'd0, cs4, busy4}, {30'd0, 1'b0, 1'b1});
        check("e0_mosi_bit7", {31'd0, mosi4}, 32'd1);
        wait_done4(base);
        check("done_time_d4", 32'(done_cyc4 - e0), 32'd68);
        check("sck_rises", rises4, 32'd8);
        tick(1);
        check("cs_high_after", {30'd0, cs4, done4}, {30'd0, 1'b1, 1'b0});

        // Starts during a transfer are ignored
        base = done_cnt4;
        go4(8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C);
        tick(9);
        tx4 = 8'hFF; start4 = 1'b1; tick(1); start4 = 1'b0;
        tick(56);
        tx4 = 8'h00; start4 = 1'b1; tick(1); start4 = 1'b0;
        check("rx_held_e0p67", {24'd0, rx4}, 32'hA5);
        wait_done4(base);
        check("done_time_ign", 32'(done_cyc4 - e0), 32'd68);
        tick(40);
        check("one_done_only", 32'(done_cnt4 - base), 32'd1);
        check("idle_after_ign", {31'd0, busy4}, 32'd0);

        // Pattern slave, two kept bytes, then cs_release
        mode4 = 2'd1;
        cs_rises4 = 0;
        base = done_cnt4;
        go4(8'h12, 1'b1, 1'b0, 1'b1, 8'hAB);
        wait_done4(base);
        base = done_cnt4;
        go4(8'h34, 1'b1, 1'b0, 1'b1, 8'hAB);
        check("kept_next_e0", 32'(e0 - done_cyc4), 32'd1);
        wait_done4(base);
        tick(3);
        check("cs_never_rose", cs_rises4, 32'd0);
        check("cs_kept_low", {31'd0, cs4}, 32'd0);
        cs_rel4 = 1'b1; tick(1); cs_rel4 = 1'b0;
        check("cs_release", {31'd0, cs4}, 32'd1);

        // Tied MISO
        mode4 = 2'd2;
        base = done_cnt4;
        go4(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
        wait_done4(base);
        mode4 = 2'd3;
        base = done_cnt4;
        go4(8'hFF, 1'b0, 1'b0, 1'b1, 8'h00);
        wait_done4(base);

        // start and cs_release together: start wins
        mode4 = 2'd0;
        tick(2);
        base = done_cnt4;
        go4(8'h81, 1'b0, 1'b1, 1'b1, 8'h81);
        check("start_wins_cs", {30'd0, cs4, busy4}, {30'd0, 1'b0, 1'b1});
        wait_done4(base);

        // CLK_DIV = 1 loopback
        mosi_viol1 = 0;
        tx1 = 8'h3C; start1 = 1'b1;
        q1.push_back(8'h3C);
        tick(1);
        e0_1 = cyc;
        start1 = 1'b0;
        begin
            int t;
            t = 0;
            while (done_cnt1 == 0 && t < 100) begin
                tick(1);
                t++;
            end
        end
        check("done1_arrived", done_cnt1, 32'd1);
        check("done_time_d1", 32'(done_cyc1 - e0_1), 32'd17);
        check("mosi_stable_d1", mosi_viol1, 32'd0);

        tick(5);
        check("scoreboard_empty", 32'(q4.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
